// File: rtl/base_rrarb_le.sv
// Registered round-robin arbiter: one shared downstream resource, grant held through
// back-pressure and locked multi-beat transfers, rotating priority after each release.
//   state | meaning
//   IDLE  | no grant outstanding, waiting for any request
//   GRANT | resource allocated to o_gnt, waiting for accept/release
module base_rrarb_le #(
  parameter int ways      = 4,
  parameter int enc_width = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ways-1:0]      i_req,
  input  logic                 i_lock,
  input  logic                 i_r,
  output logic                 o_v,
  output logic [ways-1:0]      o_gnt,
  output logic [enc_width-1:0] o_gnt_enc
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state, state_nx;
  logic [enc_width-1:0] ptr, ptr_nx, sel_ptr;
  logic [ways-1:0]      mask, hi, win_oh, gnt_nx;
  logic [enc_width-1:0] win_enc, enc_nx;
  logic [ways-1:0]      hi_oh, lo_oh;
  logic [enc_width-1:0] hi_enc, lo_enc;
  logic                 any_req, accept, release_g;

  assign o_v       = (state == GRANT);
  assign accept    = o_v & i_r;
  assign release_g = accept & ~i_lock;
  assign any_req   = |i_req;
  // after a release the just-served index becomes the priority pointer in the same cycle
  assign sel_ptr   = (state == GRANT) ? o_gnt_enc : ptr;

  always_comb begin
    mask   = '0;
    hi_oh  = '0;
    lo_oh  = '0;
    hi_enc = '0;
    lo_enc = '0;
    for (int i = 0; i < ways; i++)
      mask[i] = (i <= int'(sel_ptr));
    hi = i_req & ~mask;
    for (int i = ways - 1; i >= 0; i--) begin
      if (hi[i]) begin
        hi_oh    = '0;
        hi_oh[i] = 1'b1;
        hi_enc   = enc_width'(i);
      end
      if (i_req[i]) begin
        lo_oh    = '0;
        lo_oh[i] = 1'b1;
        lo_enc   = enc_width'(i);
      end
    end
    win_oh  = (|hi) ? hi_oh  : lo_oh;
    win_enc = (|hi) ? hi_enc : lo_enc;
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gnt_nx   = o_gnt;
    enc_nx   = o_gnt_enc;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = GRANT;
          gnt_nx   = win_oh;
          enc_nx   = win_enc;
        end
      end
      GRANT: begin
        if (release_g) begin
          ptr_nx = o_gnt_enc;
          if (any_req) begin
            gnt_nx = win_oh;
            enc_nx = win_enc;
          end else begin
            state_nx = IDLE;
            gnt_nx   = '0;
            enc_nx   = '0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        enc_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= enc_width'(ways - 1);
      o_gnt     <= '0;
      o_gnt_enc <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      o_gnt     <= gnt_nx;
      o_gnt_enc <= enc_nx;
    end
  end

endmodule
